// File: rtl/cla_adder_if.sv
// Operand/result bundle for cla_adder. The err signal exists only when
// CLA_ADDER_RCA_CHECK_EN is defined.
interface cla_adder_if #(
  parameter int WIDTH = 8
);
  localparam int N = 4 * WIDTH;

  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] s;
  logic         c;
  logic [N-1:0] s_q;
  logic         c_q;
`ifdef CLA_ADDER_RCA_CHECK_EN
  logic         err;
`endif

  modport master (
    output a, b,
    input  s, c, s_q, c_q
`ifdef CLA_ADDER_RCA_CHECK_EN
    , input err
`endif
  );

  modport slave (
    input  a, b,
    output s, c, s_q, c_q
`ifdef CLA_ADDER_RCA_CHECK_EN
    , output err
`endif
  );
endinterface

// File: rtl/cla_adder.sv
// Two-level carry-lookahead adder (4-bit groups, 4-group blocks), carry-in 0,
// with a registered copy of the result. Optional ripple cross-check: CLA_ADDER_RCA_CHECK_EN.
module cla_adder #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  cla_adder_if.slave   bus
);
  localparam int N    = 4 * WIDTH;
  localparam int NBLK = (WIDTH + 3) / 4;

  // Flattened carries c1..c3 of a 4-wide lookahead cell.
  function automatic logic [2:0] lookahead3(input logic [2:0] g, input logic [2:0] p,
                                            input logic cin);
    logic [2:0] cy;
    cy[0] = g[0] | (p[0] & cin);
    cy[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    cy[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    return cy;
  endfunction

  function automatic logic [3:0] lookahead4(input logic [3:0] g, input logic [3:0] p,
                                            input logic cin);
    logic c4;
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & cin);
    return {c4, lookahead3(g[2:0], p[2:0], cin)};
  endfunction

  logic [N-1:0]     w_g;
  logic [N-1:0]     w_p;
  logic [N-1:0]     w_cy;
  logic [WIDTH-1:0] w_gg;
  logic [WIDTH-1:0] w_gp;
  logic [WIDTH:0]   w_gc;
  logic [N-1:0]     r_s_q;
  logic             r_c_q;

  assign w_g = bus.a & bus.b;
  assign w_p = bus.a ^ bus.b;

  // NOTE: every variable written in an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin : group_gp
    w_gg = '0;
    w_gp = '0;
    for (int k = 0; k < WIDTH; k++) begin
      w_gg[k] = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2]) | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
              | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
      w_gp[k] = &w_p[4*k +: 4];
    end
  end

  // Second level: group carries per block of 4 groups; a short last block sees G=P=0 padding.
  always_comb begin : block_lookahead
    logic [4*NBLK-1:0] v_gg;
    logic [4*NBLK-1:0] v_gp;
    logic [4*NBLK:0]   v_gc;
    v_gg = '0;
    v_gp = '0;
    v_gc = '0;
    v_gg[WIDTH-1:0] = w_gg;
    v_gp[WIDTH-1:0] = w_gp;
    for (int j = 0; j < NBLK; j++) begin
      v_gc[4*j+1 +: 4] = lookahead4(v_gg[4*j +: 4], v_gp[4*j +: 4], v_gc[4*j]);
    end
    w_gc = v_gc[WIDTH:0];
  end

  always_comb begin : bit_carries
    w_cy = '0;
    for (int k = 0; k < WIDTH; k++) begin
      w_cy[4*k]       = w_gc[k];
      w_cy[4*k+1 +: 3] = lookahead3(w_g[4*k +: 3], w_p[4*k +: 3], w_gc[k]);
    end
  end

  assign bus.s = w_p ^ w_cy;
  assign bus.c = w_gc[WIDTH];

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_q <= '0;
      r_c_q <= 1'b0;
    end else begin
      r_s_q <= bus.s;
      r_c_q <= bus.c;
    end
  end

  assign bus.s_q = r_s_q;
  assign bus.c_q = r_c_q;

`ifdef CLA_ADDER_RCA_CHECK_EN
  logic [N-1:0] w_ref_s;
  logic         w_ref_c;
  logic         r_err;

  always_comb begin : ripple_ref
    logic v_rc;
    v_rc    = 1'b0;
    w_ref_s = '0;
    for (int i = 0; i < N; i++) begin
      w_ref_s[i] = bus.a[i] ^ bus.b[i] ^ v_rc;
      v_rc       = (bus.a[i] & bus.b[i]) | (v_rc & (bus.a[i] ^ bus.b[i]));
    end
    w_ref_c = v_rc;
  end

  // Sticky until reset: one disagreement is enough to flag the core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= r_err | ({bus.c, bus.s} != {w_ref_c, w_ref_s});
  end

  assign bus.err = r_err;
`endif
endmodule

// File: tb/tb_cla_adder.sv
// Directed/random checks of cla_adder at WIDTH=8 (32-bit), WIDTH=1 (exhaustive)
// and WIDTH=5 (20-bit), including asynchronous reset of the registered outputs.
module tb_cla_adder;
  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  cla_adder_if #(.WIDTH(8)) bus8 ();
  cla_adder_if #(.WIDTH(1)) bus1 ();
  cla_adder_if #(.WIDTH(5)) bus5 ();

  cla_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  cla_adder #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  cla_adder #(.WIDTH(5)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

  initial clk = 1'b0;
  always #16 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive right after a rising edge, check combinational result mid-cycle,
  // then the registered copy just after the next rising edge.
  task automatic apply8(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [32:0] exp);
    bus8.a = a;
    bus8.b = b;
    @(negedge clk);
    check({tag, " comb"}, {31'b0, bus8.c, bus8.s}, {31'b0, exp});
    @(posedge clk);
    #1;
    check({tag, " reg"}, {31'b0, bus8.c_q, bus8.s_q}, {31'b0, exp});
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [19:0] qa, qb;
    logic [3:0]  xa, xb;

    rst_n  = 1'b0;
    bus8.a = '0; bus8.b = '0;
    bus1.a = '0; bus1.b = '0;
    bus5.a = '0; bus5.b = '0;
    #5;
    check("reset s_q", {32'b0, bus8.s_q}, 64'h0);
    check("reset c_q", {63'b0, bus8.c_q}, 64'h0);
    check("zero comb", {31'b0, bus8.c, bus8.s}, 64'h0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("zero reg", {31'b0, bus8.c_q, bus8.s_q}, 64'h0);

    apply8("0+0",         32'h0000_0000, 32'h0000_0000, 33'h0_0000_0000);
    apply8("ones+1",      32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000);
    apply8("F+1",         32'h0000_000F, 32'h0000_0001, 33'h0_0000_0010);
    apply8("FFFF+1",      32'h0000_FFFF, 32'h0000_0001, 33'h0_0001_0000);
    apply8("0FFFFFFF+1",  32'h0FFF_FFFF, 32'h0000_0001, 33'h0_1000_0000);
    apply8("alt",         32'hAAAA_AAAA, 32'h5555_5555, 33'h0_FFFF_FFFF);
    apply8("1+ones",      32'h0000_0001, 32'hFFFF_FFFF, 33'h1_0000_0000);
    apply8("8000_0000x2", 32'h8000_0000, 32'h8000_0000, 33'h1_0000_0000);
    apply8("misc",        32'h1234_5678, 32'h8765_4321, 33'h0_9999_9999);

    for (int i = 0; i < 512; i++) begin
      ra = $urandom;
      rb = $urandom;
      apply8("rand32", ra, rb, {1'b0, ra} + {1'b0, rb});
    end

    // Reset between edges clears the registered copy at once; combinational path is untouched.
    apply8("ones+ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE);
    #5;
    rst_n = 1'b0;
    #1;
    check("mid reset s_q", {32'b0, bus8.s_q}, 64'h0);
    check("mid reset c_q", {63'b0, bus8.c_q}, 64'h0);
    check("mid reset comb", {31'b0, bus8.c, bus8.s}, 64'h1_FFFF_FFFE);
    @(negedge clk);
    rst_n = 1'b1;
    check("held after release", {31'b0, bus8.c_q, bus8.s_q}, 64'h0);
    @(posedge clk);
    #1;
    check("post reset reg", {31'b0, bus8.c_q, bus8.s_q}, 64'h1_FFFF_FFFE);

    for (int i = 0; i < 256; i++) begin
      xa = i[7:4];
      xb = i[3:0];
      bus1.a = xa;
      bus1.b = xb;
      #1;
      check("w1 exhaustive", {59'b0, bus1.c, bus1.s}, {59'b0, {1'b0, xa} + {1'b0, xb}});
    end

    bus5.a = 20'hFFFFF; bus5.b = 20'h00001; #1;
    check("w5 ones+1", {43'b0, bus5.c, bus5.s}, 64'h10_0000);
    bus5.a = 20'hFFFFF; bus5.b = 20'hFFFFF; #1;
    check("w5 ones+ones", {43'b0, bus5.c, bus5.s}, 64'h1F_FFFE);
    bus5.a = 20'h0FFFF; bus5.b = 20'h00001; #1;
    check("w5 block handoff", {43'b0, bus5.c, bus5.s}, 64'h01_0000);
    for (int i = 0; i < 64; i++) begin
      qa = 20'($urandom);
      qb = 20'($urandom);
      bus5.a = qa;
      bus5.b = qb;
      #1;
      check("w5 rand", {43'b0, bus5.c, bus5.s}, {43'b0, {1'b0, qa} + {1'b0, qb}});
    end

`ifdef CLA_ADDER_RCA_CHECK_EN
    @(posedge clk);
    #1;
    check("err w8", {63'b0, bus8.err}, 64'h0);
    check("err w1", {63'b0, bus1.err}, 64'h0);
    check("err w5", {63'b0, bus5.err}, 64'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cla_adder.md
Name: cla_adder

Overview:
- Parameterised carry-lookahead adder built from 4-bit lookahead groups, with a second-level lookahead unit across groups.
- Sum and carry-out are combinational. A registered copy of both, clocked on clk, feeds pipelined datapaths.
- Drop-in replacement for the ripple-carry adder in arithmetic datapaths; results are bit-identical.

Parameters:
- WIDTH, 8, number of 4-bit groups; operand width N = 4*WIDTH (default 32 bits); legal range 1..16.

Ports:
- clk  input  1  clock; rising edge updates registered outputs
- rst_n  input  1  asynchronous active-low reset
- a  input  N  operand A, unsigned
- b  input  N  operand B, unsigned
- s  output  N  combinational sum, (a+b) mod 2^N
- c  output  1  combinational carry-out, bit N of a+b
- s_q  output  N  registered s
- c_q  output  1  registered c

Behaviour:
- Carry-in is fixed at 0; no carry-in port.
- Per bit i: g_i = a_i & b_i, p_i = a_i ^ b_i, s_i = p_i ^ c_i.
- Per 4-bit group k: carries c1..c3 are computed in flattened two-level lookahead form from the group carry-in (no rippling inside a group).
  - Group generate: G_k = g3 | p3g2 | p3p2g1 | p3p2p1g0.
  - Group propagate: P_k = p3p2p1p0.
- Group carry-ins: C_{k+1} = G_k | P_k&C_k, with C_0 = 0.
  - Computed by a second-level lookahead block over groups of 4 groups, chained between blocks.
  - A final partial block is used when WIDTH is not a multiple of 4.
- c = C_WIDTH; {c,s} equals a+b exactly for all 2^(2N) input pairs.
- s and c are purely combinational from a and b:
  - zero-cycle latency;
  - no dependency on clk or rst_n;
  - settle well within one 32 ns period.
- s_q/c_q capture s/c on every rising clk edge; one cycle latency; no enable.
- rst_n low: s_q=0 and c_q=0 immediately (asynchronous assertion).
- Deassertion of rst_n takes effect at the next rising clk edge. The combinational outputs are unaffected by reset.
- Reset asserted mid-operation discards the captured value; the first post-reset edge captures the current a+b.
- Boundaries:
  - 0+0 gives s=0, c=0.
  - all-ones + 1 wraps to s=0, c=1.
  - all-ones + all-ones gives s=all-ones minus 1, c=1.
- X/Z on inputs is not handled; inputs are required to be known.

Optional Feature:
- Macro CLA_ADDER_RCA_CHECK_EN.
- Defined:
  - An internal N-bit ripple-carry reference adder (full-adder chain, carry-in 0) runs in parallel.
  - Extra output port err (1 bit, registered) is added.
  - err sets at a rising clk edge when {c,s} differs from the reference result.
  - err is sticky until rst_n asserts; reset value 0.
- Undefined: no reference adder and no err port; area and timing are those of the lookahead core only.

Test Plan:
- a=0, b=0 -> s=0x00000000, c=0; after one clk, s_q=0, c_q=0.
- a=0xFFFFFFFF, b=0x00000001 -> s=0x00000000, c=1; exercises the full carry chain across all 8 groups.
- a=0x0000000F, b=0x00000001 -> s=0x00000010, c=0; a=0x0FFFFFFF, b=0x1 -> s=0x10000000; checks group and block carry hand-off.
- 512 random a/b pairs, held 32 ns each -> s equals (a+b) mod 2^32 at each check point, and c equals bit 32 of the sum; with CLA_ADDER_RCA_CHECK_EN defined, err stays 0.
- a=0xFFFFFFFF, b=0xFFFFFFFF, then pull rst_n low between edges -> s_q=0, c_q=0 immediately while s=0xFFFFFFFE, c=1; release rst_n -> next edge gives s_q=0xFFFFFFFE, c_q=1.
- WIDTH=1 and WIDTH=5 builds -> exhaustive check for 4-bit operands, random check for 20-bit operands; {c,s}=a+b in all cases.
